// File: rtl/pipe_share_arbiter.sv
// pipe_share_arbiter
//   Shares one fixed-latency (L-cycle, no-stall) pipelined datapath between N
//   requesters. A round-robin arbiter issues at most one operation per cycle.
//   Each issue is tagged with its requester ID. The tags travel alongside the
//   datapath, and each result is steered back to the requester that owns it.
//
//   Optional build macro: PIPE_SHARE_ARBITER_CHECK_EN
//     When defined, a sticky err flag is built. It sets when dp_valid_out
//     disagrees with the valid bit of the last tag stage. The check starts only
//     after a short warm-up, which masks stale datapath contents after reset.
//     When undefined, err is tied low and the warm-up and check logic is absent.

module pipe_share_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int L = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   res_valid,
  output logic [W-1:0]   res_data,
  output logic           dp_valid_in,
  output logic [W-1:0]   dp_a,
  output logic [W-1:0]   dp_b,
  input  logic           dp_valid_out,
  input  logic [W-1:0]   dp_out,
  output logic           idle,
  output logic [15:0]    op_count,
  output logic           err
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic           found;
  logic           fire;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;

  // Tag pipeline: entry k holds the owner of the op that has been in the
  // datapath for k cycles. Entry L lines up with dp_valid_out.
  logic           tag_valid [0:L];
  logic [IDW-1:0] tag_id    [0:L];

  // Round-robin search. Requesters at or above ptr are searched first, then the
  // ones below it, both in ascending order. This is the same as scanning
  // ptr, ptr+1, ... mod N.
  // NOTE: every variable written in this block gets a default at the top, so no latch is inferred.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int j = 0; j < N; j++) begin
      if (!found && req_valid[j] && (IDW'(j) >= ptr)) begin
        found = 1'b1;
        grant = IDW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && req_valid[j] && (IDW'(j) < ptr)) begin
        found = 1'b1;
        grant = IDW'(j);
      end
    end
  end

  assign fire = found & en;

  // Only the granted requester sees ready, and it is gated by en.
  always_comb begin
    req_ready = '0;
    for (int j = 0; j < N; j++) begin
      if (found && (grant == IDW'(j))) req_ready[j] = en;
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int j = 0; j < N; j++) begin
      if (grant == IDW'(j)) begin
        sel_a = req_a[j*W +: W];
        sel_b = req_b[j*W +: W];
      end
    end
  end

  // Pointer moves just past the winner on fire, and holds otherwise.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (fire) begin
      ptr <= (grant == IDW'(N - 1)) ? '0 : grant + 1'b1;
    end
  end

  // Issue register that drives the datapath inputs. Operands hold when there
  // is no fire, because the datapath ignores them then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_valid_in <= 1'b0;
      dp_a        <= '0;
      dp_b        <= '0;
    end else begin
      dp_valid_in <= fire;
      if (fire) begin
        dp_a <= sel_a;
        dp_b <= sel_b;
      end
    end
  end

  // Tag valid bits. Clearing them on reset makes stale datapath outputs harmless.
  // NOTE: only the valid bits of the tag array are reset; the IDs are qualified by them and need no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= L; k++) tag_valid[k] <= 1'b0;
    end else begin
      tag_valid[0] <= fire;
      for (int k = 1; k <= L; k++) tag_valid[k] <= tag_valid[k-1];
    end
  end

  // Tag IDs shift in lock-step with the valid bits.
  always_ff @(posedge clk) begin
    tag_id[0] <= grant;
    for (int k = 1; k <= L; k++) tag_id[k] <= tag_id[k-1];
  end

  // Result steering: a result reaches its owner only when the last tag stage
  // and the datapath both agree that the output is valid.
  always_comb begin
    res_valid = '0;
    for (int j = 0; j < N; j++) begin
      res_valid[j] = tag_valid[L] & dp_valid_out & (tag_id[L] == IDW'(j));
    end
  end

  assign res_data = dp_out;

  // Idle when no tag stage holds an in-flight operation.
  always_comb begin
    idle = 1'b1;
    for (int k = 0; k <= L; k++) begin
      if (tag_valid[k]) idle = 1'b0;
    end
  end

  // Count of accepted operations; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (fire) begin
      op_count <= op_count + 16'd1;
    end
  end

`ifdef PIPE_SHARE_ARBITER_CHECK_EN
  localparam int WCW = $clog2(L + 2);
  localparam logic [WCW-1:0] WARM_MAX = WCW'(L + 1);

  logic [WCW-1:0] warm;
  logic           warm_done;

  assign warm_done = (warm == WARM_MAX);

  // Warm-up counter: runs 0..L+1 after reset and then saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm <= '0;
    end else if (!warm_done) begin
      warm <= warm + 1'b1;
    end
  end

  // Sticky mismatch flag between the datapath valid and the tag valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (warm_done && (dp_valid_out != tag_valid[L])) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Testbench for pipe_share_arbiter. It contains a behavioural L-stage AND
// datapath, an arbitration model and a result scoreboard.

module tb_pipe_share_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int L = 4;

`ifdef PIPE_SHARE_ARBITER_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           en = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   res_valid;
  logic [W-1:0]   res_data;
  logic           dp_valid_in;
  logic [W-1:0]   dp_a;
  logic [W-1:0]   dp_b;
  logic           dp_valid_out;
  logic [W-1:0]   dp_out;
  logic           idle;
  logic [15:0]    op_count;
  logic           err;
  logic           inject = 1'b0;

  int checks = 0;
  int failures = 0;
  int res_seen = 0;
  int m_ptr = 0;

  typedef struct {
    int         id;
    logic [W-1:0] data;
  } sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;

  // Datapath model: L registered stages of AND. It has no reset.
  logic         dp_v [0:L-1];
  logic [W-1:0] dp_d [0:L-1];
  always @(posedge clk) begin
    dp_v[0] <= dp_valid_in;
    dp_d[0] <= dp_a & dp_b;
    for (int k = 1; k < L; k++) begin
      dp_v[k] <= dp_v[k-1];
      dp_d[k] <= dp_d[k-1];
    end
  end
  assign dp_valid_out = dp_v[L-1] | inject;
  assign dp_out       = dp_d[L-1];

  pipe_share_arbiter #(.N(N), .W(W), .L(L)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .res_valid(res_valid), .res_data(res_data),
    .dp_valid_in(dp_valid_in), .dp_a(dp_a), .dp_b(dp_b),
    .dp_valid_out(dp_valid_out), .dp_out(dp_out),
    .idle(idle), .op_count(op_count), .err(err)
  );

  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Every cycle: check ready against the model, record issues, and score results.
  task automatic monitor();
    int g;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_onehot;
    sb_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        g = model_grant(req_valid, m_ptr);
        exp_ready = '0;
        if (g >= 0 && en === 1'b1) exp_ready = N'(1) << g;
        checks++;
        if (req_ready !== exp_ready) begin
          failures++;
          $display("FAIL arb_ready t=%0t: got %b want %b", $time, req_ready, exp_ready);
        end
        if (g >= 0 && en === 1'b1) begin
          sb.push_back('{id: g, data: req_a[g*W +: W] & req_b[g*W +: W]});
          m_ptr = (g + 1) % N;
        end
        if (res_valid !== '0) begin
          res_seen++;
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_result t=%0t: res_valid=%b with nothing outstanding", $time, res_valid);
          end else begin
            e = sb.pop_front();
            exp_onehot = N'(1) << e.id;
            if (res_valid !== exp_onehot || res_data !== e.data) begin
              failures++;
              $display("FAIL result t=%0t: got valid=%b data=%h want valid=%b data=%h",
                       $time, res_valid, res_data, exp_onehot, e.data);
            end
          end
        end
      end
    end
  endtask

  // Short reset pulse between two clock edges. The datapath model keeps its contents.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    m_ptr = 0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    req_valid = '0;
    repeat (L + 3) @(negedge clk);
    checks++;
    if (sb.size() != 0 || idle !== 1'b1) begin
      failures++;
      $display("FAIL drain: outstanding=%0d idle=%b want 0 and 1", sb.size(), idle);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (dp_valid_in !== 1'b0 || dp_a !== '0 || dp_b !== '0) begin
      failures++;
      $display("FAIL reset_issue: dp_valid_in=%b dp_a=%h dp_b=%h want 0", dp_valid_in, dp_a, dp_b);
    end
    checks++;
    if (res_valid !== '0 || op_count !== 16'd0 || err !== 1'b0 || idle !== 1'b1 || req_ready !== '0) begin
      failures++;
      $display("FAIL reset_state: res_valid=%b op_count=%h err=%b idle=%b ready=%b",
               res_valid, op_count, err, idle, req_ready);
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_op();
    do_reset();
    en = 1'b1;
    req_valid = 4'b0100;
    req_a[2*W +: W] = 8'hF0;
    req_b[2*W +: W] = 8'h3C;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100 || idle !== 1'b1) begin
      failures++;
      $display("FAIL single_c0: ready=%b idle=%b want 0100 1", req_ready, idle);
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (dp_valid_in !== 1'b1 || dp_a !== 8'hF0 || dp_b !== 8'h3C || op_count !== 16'd1) begin
      failures++;
      $display("FAIL single_c1: dp_valid_in=%b dp_a=%h dp_b=%h op_count=%0d want 1 f0 3c 1",
               dp_valid_in, dp_a, dp_b, op_count);
    end
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== '0 || idle !== 1'b0) begin
        failures++;
        $display("FAIL single_wait c%0d: res_valid=%b idle=%b want 0000 0", c, res_valid, idle);
      end
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 4'b0100 || res_data !== 8'h30) begin
      failures++;
      $display("FAIL single_c5: res_valid=%b res_data=%h want 0100 30", res_valid, res_data);
    end
    @(negedge clk);
    checks++;
    if (idle !== 1'b1 || res_valid !== '0) begin
      failures++;
      $display("FAIL single_c6: idle=%b res_valid=%b want 1 0000", idle, res_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seq [0:15];
    logic [W-1:0] dat [0:15];
    int           cyc [0:15];
    int n = 0;
    do_reset();
    en = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 8'hFF;
      req_b[i*W +: W] = W'(i);
    end
    for (int c = 0; c < 20; c++) begin
      if (c == 8) begin
        @(posedge clk); #1;
        req_valid = '0;
      end
      @(negedge clk);
      if (c < 8) begin
        checks++;
        if (req_ready !== (N'(1) << (c % N))) begin
          failures++;
          $display("FAIL rr_grant c%0d: ready=%b want %b", c, req_ready, N'(1) << (c % N));
        end
      end
      if (res_valid !== '0 && n < 16) begin
        seq[n] = res_valid; dat[n] = res_data; cyc[n] = c; n++;
      end
    end
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL rr_count: got %0d results want 8", n);
    end
    for (int j = 0; j < n && j < 8; j++) begin
      checks++;
      if (seq[j] !== (N'(1) << (j % N)) || dat[j] !== W'(j % N) || cyc[j] != 1 + L + j) begin
        failures++;
        $display("FAIL rr_result %0d: valid=%b data=%h cycle=%0d want %b %h %0d",
                 j, seq[j], dat[j], cyc[j], N'(1) << (j % N), W'(j % N), 1 + L + j);
      end
    end
    drain();
  endtask

  task automatic test_pointer();
    logic [N-1:0] vin  [0:5] = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b1011, 4'b1011};
    logic [N-1:0] want [0:5] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0001, 4'b0010};
    do_reset();
    en = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'(8'h11 * (i + 1));
      req_b[i*W +: W] = 8'hAA;
    end
    for (int s = 0; s < 6; s++) begin
      if (s > 0) begin
        @(posedge clk); #1;
      end
      req_valid = vin[s];
      @(negedge clk);
      checks++;
      if (req_ready !== want[s]) begin
        failures++;
        $display("FAIL ptr_step %0d: ready=%b want %b", s, req_ready, want[s]);
      end
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_en_drain();
    int base;
    do_reset();
    base = res_seen;
    en = 1'b1;
    req_valid = '1;
    @(posedge clk); @(posedge clk); #1;
    en = 1'b0;
    for (int c = 0; c < L + 4; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== '0) begin
        failures++;
        $display("FAIL en_block c%0d: ready=%b want 0000", c, req_ready);
      end
    end
    checks++;
    if (res_seen - base != 2 || idle !== 1'b1 || op_count !== 16'd2) begin
      failures++;
      $display("FAIL en_drain: results=%0d idle=%b op_count=%0d want 2 1 2", res_seen - base, idle, op_count);
    end
    @(posedge clk); #1;
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL en_resume: ready=%b want 0100", req_ready);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    en = 1'b1;
    req_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    req_valid = '0;
    rst_n = 1'b0;
    sb.delete();
    m_ptr = 0;
    #2 rst_n = 1'b1;
    base = res_seen;
    repeat (L + 8) @(negedge clk);
    checks++;
    if (res_seen != base || op_count !== 16'd0 || err !== 1'b0 || idle !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid: results=%0d op_count=%0d err=%b idle=%b want 0 0 0 1",
               res_seen - base, op_count, err, idle);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    en = 1'b1;
    req_valid = '1;
    repeat (65536) @(negedge clk);
    checks++;
    if (op_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap_ffff: op_count=%h want ffff", op_count);
    end
    @(negedge clk);
    checks++;
    if (op_count !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_zero: op_count=%h want 0000", op_count);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_err_inject();
    do_reset();
    en = 1'b1;
    req_valid = '0;
    repeat (L + 4) @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_pre: err=%b want 0", err);
    end
    @(posedge clk); #1;
    inject = 1'b1;
    @(negedge clk);
    checks++;
    if (res_valid !== '0) begin
      failures++;
      $display("FAIL err_res: res_valid=%b want 0000", res_valid);
    end
    @(posedge clk); #1;
    inject = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (err !== CHK) begin
        failures++;
        $display("FAIL err_sticky c%0d: err=%b want %b", c, err, CHK);
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_op();
    test_round_robin();
    test_pointer();
    test_en_drain();
    test_reset_mid();
    test_wrap();
    test_err_inject();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
